// File: rtl/ser_frame_pkg.sv
// Shared types and elaboration helpers for the serial frame transmitter.
// Holds the FSM state encoding and the width calculation for the shared
// bit/gap down-counter.
package ser_frame_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } ser_state_t;

   // The counter is shared between the bit count and the gap count, so it
   // must hold whichever of the two load values is larger.
   function automatic int cnt_width(input int width, input int gap);
      int span;
      span = (width + 1 > gap + 1) ? width + 1 : gap + 1;
      return (span < 2) ? 1 : $clog2(span);
   endfunction

endpackage

// File: rtl/ser_frame_tx_if.sv
// Parallel word handshake between a word producer and ser_frame_tx.
// The producer (master) offers data_in and msb_first under in_valid.
// The transmitter (slave) answers with in_ready.
interface ser_frame_tx_if #(
   parameter int WIDTH = 8
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_in;
   logic             msb_first;

   modport master (
      output in_valid,
      output data_in,
      output msb_first,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  data_in,
      input  msb_first,
      output in_ready
   );

endinterface

// File: rtl/ser_bit_counter.sv
// Loadable down-counter with a zero flag.
// The transmitter uses one instance for both the frame bit count and the
// inter-frame gap count. Decrementing past zero is blocked, so the count
// cannot wrap even if dec is raised while zero is set.
module ser_bit_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          zero
);

   assign zero = (count == '0);

   // Load takes priority over decrement; hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/ser_frame_tx.sv
// Parallel-in, serial-out frame transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake, streams it one bit
// per clock (MSB- or LSB-first), then idles for GAP_CYCLES before
// re-accepting. All outputs are registered.
// Build option: define SER_FRAME_PARITY_EN to append an even-parity bit
// after the data bits; frame_done then marks the parity bit.
module ser_frame_tx
   import ser_frame_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter int   GAP_CYCLES = 2,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ser_frame_tx_if.slave        bus,
   output logic                 ser_out,
   output logic                 ser_valid,
   output logic                 frame_start,
   output logic                 frame_done,
   output logic                 busy
);

   localparam int CW = cnt_width(WIDTH, GAP_CYCLES);

`ifdef SER_FRAME_PARITY_EN
   localparam int LAST_IDX = WIDTH;
`else
   localparam int LAST_IDX = WIDTH - 1;
`endif

   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   localparam logic [CW-1:0] BIT_LOAD = LAST_IDX[CW-1:0];
   localparam logic [CW-1:0] GAP_LOAD = GAP_LAST[CW-1:0];
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   // A single-bit word would need frame_start and frame_done in the same
   // cycle, which the output timing does not support.
   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("ser_frame_tx: WIDTH must be at least 2");
      end
   endgenerate

   ser_state_t       state_q;
   ser_state_t       state_nx;
   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] word_nx;
   logic             order_q;
   logic             order_nx;
   logic             in_ready_q;
   logic             in_ready_nx;
   logic             ser_out_nx;
   logic             ser_valid_nx;
   logic             frame_start_nx;
   logic             frame_done_nx;
   logic             busy_nx;
   logic             accept;
   logic             cnt_load;
   logic [CW-1:0]    cnt_load_val;
   logic             cnt_dec;
   logic [CW-1:0]    cnt;
   logic             cnt_zero;
`ifdef SER_FRAME_PARITY_EN
   logic             par_q;
   logic             par_nx;
`endif

   assign bus.in_ready = in_ready_q;
   assign accept       = (state_q == IDLE) && in_ready_q && bus.in_valid;

   ser_bit_counter #(
      .CW (CW)
   ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   // State register for the IDLE/SHIFT/GAP sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   // Next-state and next-output decode. The first bit is registered at the
   // accept edge, so the word register holds only the bits still to send
   // and the counter holds how many of them remain after the current one.
   always_comb begin
      state_nx       = state_q;
      word_nx        = word_q;
      order_nx       = order_q;
      in_ready_nx    = 1'b0;
      ser_out_nx     = IDLE_LEVEL;
      ser_valid_nx   = 1'b0;
      frame_start_nx = 1'b0;
      frame_done_nx  = 1'b0;
      cnt_load       = 1'b0;
      cnt_load_val   = BIT_LOAD;
      cnt_dec        = 1'b0;
`ifdef SER_FRAME_PARITY_EN
      par_nx         = par_q;
`endif

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_nx       = SHIFT;
               order_nx       = bus.msb_first;
               ser_valid_nx   = 1'b1;
               frame_start_nx = 1'b1;
               cnt_load       = 1'b1;
               cnt_load_val   = BIT_LOAD;
               if (bus.msb_first) begin
                  ser_out_nx = bus.data_in[WIDTH-1];
                  word_nx    = {bus.data_in[WIDTH-2:0], 1'b0};
               end else begin
                  ser_out_nx = bus.data_in[0];
                  word_nx    = {1'b0, bus.data_in[WIDTH-1:1]};
               end
`ifdef SER_FRAME_PARITY_EN
               par_nx = ^bus.data_in;
`endif
            end else begin
               in_ready_nx = 1'b1;
            end
         end

         SHIFT: begin
            if (!cnt_zero) begin
               cnt_dec       = 1'b1;
               ser_valid_nx  = 1'b1;
               frame_done_nx = (cnt == CNT_ONE);
               if (order_q) begin
                  ser_out_nx = word_q[WIDTH-1];
                  word_nx    = {word_q[WIDTH-2:0], 1'b0};
               end else begin
                  ser_out_nx = word_q[0];
                  word_nx    = {1'b0, word_q[WIDTH-1:1]};
               end
`ifdef SER_FRAME_PARITY_EN
               if (cnt == CNT_ONE) begin
                  ser_out_nx = par_q;
               end
`endif
            end else if (GAP_CYCLES == 0) begin
               state_nx    = IDLE;
               in_ready_nx = 1'b1;
            end else begin
               state_nx     = GAP;
               cnt_load     = 1'b1;
               cnt_load_val = GAP_LOAD;
            end
         end

         GAP: begin
            if (cnt_zero) begin
               state_nx    = IDLE;
               in_ready_nx = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase

      busy_nx = (state_nx != IDLE);
   end

   // Registered outputs and datapath; reset drops everything to the idle
   // line level at once, discarding any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q      <= '0;
         order_q     <= 1'b0;
         in_ready_q  <= 1'b0;
         ser_out     <= IDLE_LEVEL;
         ser_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         word_q      <= word_nx;
         order_q     <= order_nx;
         in_ready_q  <= in_ready_nx;
         ser_out     <= ser_out_nx;
         ser_valid   <= ser_valid_nx;
         frame_start <= frame_start_nx;
         frame_done  <= frame_done_nx;
         busy        <= busy_nx;
      end
   end

`ifdef SER_FRAME_PARITY_EN
   // Parity of the accepted word, sent as the final frame bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_nx;
      end
   end
`endif

endmodule

// File: tb/tb_ser_frame_tx.sv
// Directed testbench for ser_frame_tx.
// dut_a uses GAP_CYCLES=2, dut_b uses GAP_CYCLES=0. Frame length follows
// SER_FRAME_PARITY_EN. Outputs are sampled on the falling clock edge and
// inputs are driven there too.
module tb_ser_frame_tx;

`ifdef SER_FRAME_PARITY_EN
   localparam int FLEN = 9;
`else
   localparam int FLEN = 8;
`endif
   localparam int GAP_A = 2;

   logic clk;
   logic rst_n;

   ser_frame_tx_if #(.WIDTH(8)) bus_a ();
   ser_frame_tx_if #(.WIDTH(8)) bus_b ();

   logic a_ser_out, a_ser_valid, a_frame_start, a_frame_done, a_busy;
   logic b_ser_out, b_ser_valid, b_frame_start, b_frame_done, b_busy;

   int check_count = 0;
   int pass_count  = 0;

   ser_frame_tx #(.WIDTH(8), .GAP_CYCLES(GAP_A), .IDLE_LEVEL(1'b1)) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_a),
      .ser_out     (a_ser_out),
      .ser_valid   (a_ser_valid),
      .frame_start (a_frame_start),
      .frame_done  (a_frame_done),
      .busy        (a_busy)
   );

   ser_frame_tx #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_b),
      .ser_out     (b_ser_out),
      .ser_valid   (b_ser_valid),
      .frame_start (b_frame_start),
      .frame_done  (b_frame_done),
      .busy        (b_busy)
   );

   // 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference bit i of a frame: data bits in the chosen order, then parity.
   function automatic logic expBit(input logic [7:0] word, input logic msb, input int i);
      if (i >= 8) return ^word;
      return msb ? word[7-i] : word[i];
   endfunction

   // Status word {ser_valid, ser_out, frame_start, frame_done, busy, in_ready} of dut_a.
   function automatic logic [5:0] statusA();
      return {a_ser_valid, a_ser_out, a_frame_start, a_frame_done, a_busy, bus_a.in_ready};
   endfunction

   // Send one word on dut_a and check every bit, the gap and the return to idle.
   // pattern lists the data bits first-bit-first; par is the expected parity bit.
   task automatic applyStimulus(input logic [7:0] word, input logic msb,
                                input logic [7:0] pattern, input logic par);
      int  waited;
      logic eb;
      waited = 0;
      while (!bus_a.in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput($sformatf("ready before %h", word), 32'(bus_a.in_ready), 32'd1);
      bus_a.in_valid  = 1'b1;
      bus_a.data_in   = word;
      bus_a.msb_first = msb;
      @(negedge clk);
      bus_a.in_valid  = 1'b0;
      bus_a.data_in   = ~word;
      bus_a.msb_first = ~msb;
      for (int i = 0; i < FLEN; i++) begin
         eb = (i < 8) ? pattern[7-i] : par;
         checkOutput($sformatf("word %h bit %0d", word, i), 32'(statusA()),
                     32'({1'b1, eb, 1'(i == 0), 1'(i == FLEN-1), 1'b1, 1'b0}));
         @(negedge clk);
      end
      for (int g = 0; g < GAP_A; g++) begin
         checkOutput($sformatf("word %h gap %0d", word, g), 32'(statusA()), 32'(6'b010010));
         @(negedge clk);
      end
      checkOutput($sformatf("word %h idle", word), 32'(statusA()), 32'(6'b010001));
   endtask

   logic [31:0] got_vec, exp_vec;
   int          got_n, n_starts, n_dones, start1, start2, done1;
   logic        armed, dropped, saw_bad;

   initial begin
      rst_n           = 1'b0;
      bus_a.in_valid  = 1'b0;
      bus_a.data_in   = 8'h00;
      bus_a.msb_first = 1'b0;
      bus_b.in_valid  = 1'b0;
      bus_b.data_in   = 8'h00;
      bus_b.msb_first = 1'b0;

      // Reset values, then in_ready one edge after release.
      repeat (2) @(negedge clk);
      checkOutput("reset status", 32'(statusA()), 32'(6'b010000));
      checkOutput("reset busy b", 32'({b_busy, bus_b.in_ready, b_ser_out}), 32'(3'b001));
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready after reset", 32'(statusA()), 32'(6'b010001));

      // Directed frames with hand-derived bit patterns.
      applyStimulus(8'hA5, 1'b1, 8'b10100101, 1'b0);
      applyStimulus(8'h01, 1'b0, 8'b10000000, 1'b1);
      applyStimulus(8'h07, 1'b1, 8'b00000111, 1'b1);
      applyStimulus(8'h03, 1'b0, 8'b11000000, 1'b0);

      // in_valid held high: FF then 00, data_in scrambled mid-frame.
      checkOutput("ready before stream", 32'(bus_a.in_ready), 32'd1);
      bus_a.in_valid  = 1'b1;
      bus_a.data_in   = 8'hFF;
      bus_a.msb_first = 1'b1;
      armed = 1'b0; dropped = 1'b0; got_vec = '0; got_n = 0;
      n_starts = 0; start1 = 0; start2 = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (a_ser_valid) begin
            got_vec = {got_vec[30:0], a_ser_out};
            got_n++;
         end
         if (a_frame_start) begin
            n_starts++;
            if (n_starts == 1) start1 = c;
            else if (n_starts == 2) start2 = c;
         end
         if (armed && !dropped) begin
            bus_a.in_valid = 1'b0;
            dropped = 1'b1;
         end else if (!armed) begin
            if (bus_a.in_ready) begin
               bus_a.data_in = 8'h00;
               armed = 1'b1;
            end else begin
               bus_a.data_in   = 8'($urandom);
               bus_a.msb_first = 1'($urandom);
            end
         end
      end
      exp_vec = '0;
      for (int i = 0; i < FLEN; i++) exp_vec = {exp_vec[30:0], expBit(8'hFF, 1'b1, i)};
      for (int i = 0; i < FLEN; i++) exp_vec = {exp_vec[30:0], expBit(8'h00, 1'b1, i)};
      checkOutput("stream starts", 32'(n_starts), 32'd2);
      checkOutput("stream accept period", 32'(start2 - start1), 32'(FLEN + GAP_A + 1));
      checkOutput("stream bit count", 32'(got_n), 32'(2 * FLEN));
      checkOutput("stream bits", got_vec, exp_vec);

      // Reset asserted after the third bit of C3.
      bus_a.in_valid  = 1'b1;
      bus_a.data_in   = 8'hC3;
      bus_a.msb_first = 1'b1;
      @(negedge clk);
      bus_a.in_valid  = 1'b0;
      bus_a.data_in   = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("c3 bit %0d", i), 32'({a_ser_valid, a_ser_out}),
                     32'({1'b1, expBit(8'hC3, 1'b1, i)}));
         if (i < 2) @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1 checkOutput("async reset", 32'(statusA()), 32'(6'b010000));
      @(negedge clk);
      checkOutput("held reset", 32'(statusA()), 32'(6'b010000));
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready after mid-frame reset", 32'(statusA()), 32'(6'b010001));
      saw_bad = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (a_ser_valid || a_frame_done || a_frame_start) saw_bad = 1'b1;
      end
      checkOutput("no frame after reset", 32'(saw_bad), 32'd0);

      // GAP_CYCLES=0: 5A MSB-first then 96 LSB-first, back to back.
      checkOutput("b ready", 32'(bus_b.in_ready), 32'd1);
      bus_b.in_valid  = 1'b1;
      bus_b.data_in   = 8'h5A;
      bus_b.msb_first = 1'b1;
      armed = 1'b0; dropped = 1'b0; got_vec = '0; got_n = 0;
      n_starts = 0; n_dones = 0; start1 = 0; start2 = 0; done1 = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (b_ser_valid) begin
            got_vec = {got_vec[30:0], b_ser_out};
            got_n++;
         end
         if (b_frame_start) begin
            n_starts++;
            if (n_starts == 1) start1 = c;
            else if (n_starts == 2) start2 = c;
         end
         if (b_frame_done) begin
            n_dones++;
            if (n_dones == 1) done1 = c;
         end
         if (armed && !dropped) begin
            bus_b.in_valid = 1'b0;
            dropped = 1'b1;
         end else if (!armed && bus_b.in_ready) begin
            bus_b.data_in   = 8'h96;
            bus_b.msb_first = 1'b0;
            armed = 1'b1;
         end
      end
      exp_vec = '0;
      for (int i = 0; i < FLEN; i++) exp_vec = {exp_vec[30:0], expBit(8'h5A, 1'b1, i)};
      for (int i = 0; i < FLEN; i++) exp_vec = {exp_vec[30:0], expBit(8'h96, 1'b0, i)};
      checkOutput("b starts", 32'(n_starts), 32'd2);
      checkOutput("b dones", 32'(n_dones), 32'd2);
      checkOutput("b accept period", 32'(start2 - start1), 32'(FLEN + 1));
      checkOutput("b done to next start", 32'(start2 - done1), 32'd2);
      checkOutput("b first done", 32'(done1 - start1), 32'(FLEN - 1));
      checkOutput("b bits", got_vec, exp_vec);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
